// File: rtl/load_store_unit.sv
// Load/store unit: memory stage of the RISC-V core. Issues a single outstanding
// valid/ready bus transaction per memory instruction, steers store bytes onto
// the correct lanes, extends load results and flags misaligned/illegal accesses
// and bus timeouts. Stalls the pipeline while an access is in flight.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        LoadValid,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusWStrb,
    output logic        BusWE,
    output logic        BusValid,
    input  logic        BusReady,
    input  logic [31:0] BusRData
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Counter value on the last BUSY cycle allowed before the access is aborted.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        legal;
    logic        misaligned;
    logic        check_ok;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Decode legality/alignment of the incoming request and build store lanes.
    always_comb begin
        legal = 1'b0;
        if (MemWrite) begin
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        end else begin
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b101);
        end
        misaligned = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                     ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
        check_ok   = legal && !misaligned;

        strb_next  = 4'b0000;
        wdata_next = WriteData;
        case (Funct3[1:0])
            2'b00: begin
                strb_next  = 4'b0001 << ALUResult[1:0];
                wdata_next = {4{WriteData[7:0]}};
            end
            2'b01: begin
                strb_next  = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{WriteData[15:0]}};
            end
            default: begin
                strb_next  = 4'b1111;
                wdata_next = WriteData;
            end
        endcase
        // Loads never assert byte enables.
        if (!MemWrite) begin
            strb_next = 4'b0000;
        end
    end

    // Select the addressed lane of the returned word and sign/zero extend it.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = BusRData[7:0];
            2'd1:    byte_sel = BusRData[15:8];
            2'd2:    byte_sel = BusRData[23:16];
            default: byte_sel = BusRData[31:24];
        endcase
        half_sel = off_q[1] ? BusRData[31:16] : BusRData[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = BusRData;
        endcase
    end

    assign Stall = ((state == IDLE) && MemReq && check_ok) || (state == BUSY);

    // Transaction FSM with registered bus outputs and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tmo_cnt     <= 8'd0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            ReadData    <= 32'd0;
            LoadValid   <= 1'b0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
            BusAddr     <= 32'd0;
            BusWData    <= 32'd0;
            BusWStrb    <= 4'b0000;
            BusWE       <= 1'b0;
            BusValid    <= 1'b0;
        end else begin
            LoadValid   <= 1'b0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemReq) begin
                        if (check_ok) begin
                            BusAddr  <= {ALUResult[31:2], 2'b00};
                            BusWE    <= MemWrite;
                            BusWStrb <= strb_next;
                            BusWData <= wdata_next;
                            funct3_q <= Funct3;
                            off_q    <= ALUResult[1:0];
                            BusValid <= 1'b1;
                            tmo_cnt  <= 8'd0;
                            state    <= BUSY;
                        end else begin
                            MisalignErr <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // A handshake on the timeout cycle still counts as success.
                    if (BusReady) begin
                        BusValid <= 1'b0;
                        state    <= RESP;
                        if (!BusWE) begin
                            ReadData  <= load_ext;
                            LoadValid <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        BusValid <= 1'b0;
                        BusErr   <= 1'b1;
                        ReadData <= 32'd0;
                        state    <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    // MemReq here belongs to the completing instruction.
                    tmo_cnt <= 8'd0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected status pulses
// plus per-cycle checks of the bus interface and Stall.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;
    localparam int NEVER = 99;

    logic        clk;
    logic        rst_n;
    logic        MemReq;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        Stall;
    logic [31:0] ReadData;
    logic        LoadValid;
    logic        MisalignErr;
    logic        BusErr;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic [3:0]  BusWStrb;
    logic        BusWE;
    logic        BusValid;
    logic        BusReady;
    logic [31:0] BusRData;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemReq      (MemReq),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .Stall       (Stall),
        .ReadData    (ReadData),
        .LoadValid   (LoadValid),
        .MisalignErr (MisalignErr),
        .BusErr      (BusErr),
        .BusAddr     (BusAddr),
        .BusWData    (BusWData),
        .BusWStrb    (BusWStrb),
        .BusWE       (BusWE),
        .BusValid    (BusValid),
        .BusReady    (BusReady),
        .BusRData    (BusRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pulse pattern {LoadValid, BusErr, MisalignErr} and ReadData.
    typedef struct packed {
        logic [2:0]  pulses;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every status pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (LoadValid || BusErr || MisalignErr)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, LoadValid, BusErr, MisalignErr}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pulse", {29'd0, LoadValid, BusErr, MisalignErr}, {29'd0, e.pulses});
                if (e.pulses != 3'b001) chk("rdata", ReadData, e.data);
            end
        end
    end

    // Issue one access and follow it cycle by cycle back to IDLE.
    task automatic access(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ready_at, input logic ok,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rd);
        logic tmo;
        exp_t e;
        MemReq    = 1'b1;
        MemWrite  = we;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wdata;
        if (!ok) begin
            e.pulses = 3'b001;
            e.data   = 32'd0;
            sb_q.push_back(e);
        end
        @(negedge clk);
        chk({name, "_stall_issue"}, 32'(Stall), 32'(ok));
        chk({name, "_valid_idle"}, 32'(BusValid), 32'd0);
        @(posedge clk);
        #1;
        MemReq = 1'b0;
        if (!ok) begin
            @(negedge clk);
            chk({name, "_valid_err"}, 32'(BusValid), 32'd0);
            chk({name, "_stall_err"}, 32'(Stall), 32'd0);
            @(posedge clk);
            #1;
            chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
            return;
        end
        tmo = (ready_at >= int'(TMO));
        if (tmo) begin
            e.pulses = 3'b010;
            e.data   = 32'd0;
            sb_q.push_back(e);
        end else if (!we) begin
            e.pulses = 3'b100;
            e.data   = exp_rd;
            sb_q.push_back(e);
        end
        for (int c = 0; c < int'(TMO); c++) begin
            BusReady = (c == ready_at);
            BusRData = rdata;
            @(negedge clk);
            chk({name, "_valid_busy"}, 32'(BusValid), 32'd1);
            chk({name, "_stall_busy"}, 32'(Stall), 32'd1);
            chk({name, "_addr"}, BusAddr, {addr[31:2], 2'b00});
            chk({name, "_strb"}, 32'(BusWStrb), 32'(exp_strb));
            chk({name, "_we"}, 32'(BusWE), 32'(we));
            if (we) chk({name, "_wdata"}, BusWData, exp_wdata);
            @(posedge clk);
            #1;
            BusReady = 1'b0;
            if (c == ready_at) break;
        end
        // RESP cycle
        @(negedge clk);
        chk({name, "_stall_resp"}, 32'(Stall), 32'd0);
        chk({name, "_valid_resp"}, 32'(BusValid), 32'd0);
        if (we && !tmo) chk({name, "_rd_hold"}, ReadData, last_rd);
        if (tmo) last_rd = 32'd0;
        else if (!we) last_rd = exp_rd;
        @(posedge clk);
        #1;
        chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        ALUResult = 32'd0;
        WriteData = 32'd0;
        BusReady  = 1'b0;
        BusRData  = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_pulses", {29'd0, LoadValid, BusErr, MisalignErr}, 32'd0);
        chk("rst_bus", {BusValid, BusWE, BusWStrb}, 32'd0);
        chk("rst_addr", BusAddr, 32'd0);
        chk("rst_wdata", BusWData, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Loads with lane extraction (we, f3, addr, wdata, rdata, ready_at, ok, strb, wd, rd)
        access("lw",   1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, 4'h0, 32'h0, 32'hDEADBEEF);
        access("lb3",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b1, 4'h0, 32'h0, 32'hFFFFFF80);
        access("lbu3", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b1, 4'h0, 32'h0, 32'h00000080);
        access("lh2",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 1'b1, 4'h0, 32'h0, 32'hFFFF80FF);
        access("lhu0", 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 1, 1'b1, 4'h0, 32'h0, 32'h00001234);
        access("lb1",  1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 0, 1'b1, 4'h0, 32'h0, 32'h00000012);
        access("lhu2", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 1'b1, 4'h0, 32'h0, 32'h000080FF);

        // Stores with lane steering
        access("sb1",  1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0);
        access("sh2",  1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 0, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h0);
        access("sw",   1'b1, 3'b010, 32'h204, 32'h12345678, 32'h0, 2, 1'b1, 4'b1111, 32'h12345678, 32'h0);
        access("sb3",  1'b1, 3'b000, 32'h203, 32'h0000005A, 32'h0, 0, 1'b1, 4'b1000, 32'h5A5A5A5A, 32'h0);
        access("sh0",  1'b1, 3'b001, 32'h208, 32'h0000C0DE, 32'h0, 1, 1'b1, 4'b0011, 32'hC0DEC0DE, 32'h0);

        // Misaligned and illegal encodings
        access("lw_mis",  1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        access("sw_ill",  1'b1, 3'b011, 32'h200, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        access("lh_mis",  1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        access("ld_ill3", 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        access("ld_ill6", 1'b0, 3'b110, 32'h000, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        access("sh_mis",  1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        access("lw_ok",   1'b0, 3'b010, 32'h10C, 32'h0, 32'h01020304, 0, 1'b1, 4'h0, 32'h0, 32'h01020304);

        // Timeouts, and a handshake on the last allowed cycle
        access("lw_tmo",  1'b0, 3'b010, 32'h104, 32'h0, 32'h0, NEVER, 1'b1, 4'h0, 32'h0, 32'h0);
        access("lw_last", 1'b0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, 3, 1'b1, 4'h0, 32'h0, 32'hCAFEF00D);
        access("sw_tmo",  1'b1, 3'b010, 32'h10C, 32'h55AA55AA, 32'h0, NEVER, 1'b1, 4'b1111, 32'h55AA55AA, 32'h0);
        access("lbu_ok",  1'b0, 3'b100, 32'h102, 32'h0, 32'h00770000, 0, 1'b1, 4'h0, 32'h0, 32'h00000077);

        // Reset in the middle of a BUSY phase after three wait cycles
        MemReq    = 1'b1;
        MemWrite  = 1'b0;
        Funct3    = 3'b010;
        ALUResult = 32'h300;
        @(posedge clk);
        #1;
        MemReq   = 1'b0;
        BusReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_valid_before", 32'(BusValid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(BusValid), 32'd0);
        chk("rst_mid_stall", 32'(Stall), 32'd0);
        chk("rst_mid_rdata", ReadData, 32'd0);
        last_rd = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_retry", 32'(BusValid), 32'd0);
        @(posedge clk);
        #1;
        access("lw_post_rst", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 0, 1'b1, 4'h0, 32'h0, 32'h0BADF00D);
        access("tmo_post_rst", 1'b0, 3'b010, 32'h404, 32'h0, 32'h0, NEVER, 1'b1, 4'h0, 32'h0, 32'h0);

        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the RISC-V core, directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a single outstanding valid/ready transaction on the data bus, with byte-lane steering and load sign/zero extension.
- Stalls the pipeline until the access completes; flags misaligned accesses, illegal funct3 encodings and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, number of BUSY cycles without BusReady before abort (1..255; counter is 8 bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemReq  in  1  memory instruction present in this stage
MemWrite  in  1  1 = store, 0 = load
Funct3  in  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
ALUResult  in  32  effective byte address
WriteData  in  32  store data (rs2)
Stall  out  1  hold upstream pipeline (combinational)
ReadData  out  32  extended load result, valid with LoadValid
LoadValid  out  1  one-cycle pulse, load data ready
MisalignErr  out  1  one-cycle pulse, misaligned address or illegal funct3
BusErr  out  1  one-cycle pulse, transaction timed out
BusAddr  out  32  word address {ALUResult[31:2],2'b00}
BusWData  out  32  lane-replicated store data
BusWStrb  out  4  byte enables (0000 for loads)
BusWE  out  1  write enable
BusValid  out  1  request valid
BusReady  in  1  request accepted/completed this cycle
BusRData  in  32  read data, valid when BusValid&&BusReady&&!BusWE

Behaviour:
- Reset is asynchronous, active-low.
  - FSM goes to IDLE; timeout counter clears.
  - All registered outputs go to 0: ReadData, LoadValid, MisalignErr, BusErr, BusAddr, BusWData, BusWStrb, BusWE, BusValid.
  - Any in-flight bus transaction is abandoned; no retry is issued after reset.
- FSM states: IDLE, BUSY, RESP.
- Checks in IDLE when MemReq=1:
  - Halfword access (LH, LHU, SH) with ALUResult[0]=1 is misaligned.
  - Word access (LW, SW) with ALUResult[1:0]!=0 is misaligned.
  - Illegal encodings: load funct3 011/110/111; store funct3 >=011.
- IDLE, MemReq=1, check fails:
  - MisalignErr pulses in the next cycle.
  - No bus access; stay in IDLE; Stall=0.
- IDLE, MemReq=1, check passes:
  - Latch BusAddr, BusWE=MemWrite, BusWStrb, BusWData, Funct3 and offset ALUResult[1:0].
  - Go to BUSY with BusValid=1 from the next cycle.
- Store lane steering:
  - SB: strobe 0001<<off; data {4{WriteData[7:0]}}.
  - SH: strobe 0011<<(off[1]*2); data {2{WriteData[15:0]}}.
  - SW: strobe 1111; data WriteData.
- BUSY:
  - BusValid stays high; all bus outputs are stable until BusReady.
  - BusReady=1 → go to RESP, drop BusValid; for loads, latch the extracted lane.
  - Timeout counter increments each BUSY cycle without BusReady. At TIMEOUT_CYCLES, drop BusValid and go to RESP with the error flagged.
  - BusReady in the same cycle as the timeout has priority: success, no error.
- Load extraction: LB/LBU take byte BusRData[8*off+:8]; LH/LHU take half BusRData[16*off[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP (exactly one cycle):
  - Load success: LoadValid=1, ReadData valid.
  - Timeout: BusErr=1, ReadData=0, LoadValid=0, for loads and stores alike.
  - Store success: no pulse.
  - Then go to IDLE. MemReq seen during RESP belongs to the completing instruction and is ignored.
- Stall = (IDLE && MemReq && checks pass) || BUSY. Stall is 0 in RESP so the pipeline advances at the end of RESP.
- Latency: load with zero-wait BusReady takes 3 cycles (IDLE, BUSY, RESP); Stall is high for 2 cycles. Each bus wait cycle adds 1.
- ReadData holds its value until the next successful load or timeout; pulse outputs are 0 otherwise.
- Back-to-back accesses: a new MemReq is accepted in the IDLE cycle directly after RESP, giving at most one bus request per 3 cycles.

Test Plan:
- LW, ALUResult=0x100, BusReady=1 in first BUSY cycle, BusRData=0xDEADBEEF → BusAddr=0x100, BusWStrb=0000, LoadValid with ReadData=0xDEADBEEF in cycle 2, Stall high cycles 0–1 only.
- LB at 0x103 and LBU at 0x103, BusRData=0x80FF1234 → ReadData 0xFFFFFF80 then 0x00000080; LH at 0x102 → 0xFFFF80FF.
- SB at 0x0201, WriteData=0x000000A5 → BusAddr=0x200, BusWStrb=0010, BusWData=0xA5A5A5A5, BusWE=1; SH at 0x202 → strobe 1100.
- LW at 0x102, then SW with Funct3=011 → MisalignErr pulse each, BusValid never rises, Stall stays 0.
- TIMEOUT_CYCLES=4, BusReady held 0 → BusValid high 4 cycles, then BusErr pulse, ReadData=0, Stall drops. Repeat with BusReady=1 on the 4th cycle → normal completion, no BusErr.
- Assert rst_n=0 mid-BUSY with 3 wait cycles elapsed → BusValid and Stall 0 immediately; after release FSM is IDLE, counter 0, and a fresh LW completes normally.
